// File: rtl/array_scan_scheduler.sv
// Raster scan scheduler: walks an H_ACTIVE x V_ACTIVE frame in groups of LANES
// pixels and hands each group to a processing array, with idle gaps between lines.
module array_scan_scheduler #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int LANES      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             pe_ready,
  output logic             issue_valid,
  output logic [9:0]       xpos,
  output logic [9:0]       ypos,
  output logic [LANES-1:0] lane_mask,
  output logic             line_end,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [9:0] xpos_reg, xpos_next;
  logic [9:0] ypos_reg, ypos_next;
  logic [3:0] gap_reg, gap_next;

  // 11-bit views so xpos+LANES cannot wrap before the comparison.
  logic [10:0] xpos_ext;
  logic [10:0] xpos_adv;
  logic        scan_c;
  logic        line_end_c;
  logic        last_line_c;
  logic        transfer_c;

  assign xpos_ext    = {1'b0, xpos_reg};
  assign xpos_adv    = xpos_ext + 11'(LANES);
  assign scan_c      = (state_reg == SCAN);
  assign line_end_c  = (xpos_adv >= 11'(H_ACTIVE));
  assign last_line_c = ({1'b0, ypos_reg} == 11'(V_ACTIVE - 1));
  assign transfer_c  = scan_c && ena && pe_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      xpos_reg  <= '0;
      ypos_reg  <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      xpos_reg  <= xpos_next;
      ypos_reg  <= ypos_next;
      gap_reg   <= gap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    xpos_next  = xpos_reg;
    ypos_next  = ypos_reg;
    gap_next   = gap_reg;
    if (ena) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = SCAN;
            xpos_next  = '0;
            ypos_next  = '0;
          end
        end
        SCAN: begin
          if (transfer_c) begin
            if (!line_end_c) begin
              xpos_next = xpos_adv[9:0];
            end else if (last_line_c) begin
              state_next = DONE;
            end else begin
              xpos_next = '0;
              ypos_next = ypos_reg + 10'd1;
              if (GAP_CYCLES > 0) begin
                state_next = GAP;
                gap_next   = 4'(GAP_CYCLES - 1);
              end
            end
          end
        end
        GAP: begin
          // gap_reg counts remaining gap cycles after this one.
          if (gap_reg == 4'd0) begin
            state_next = SCAN;
          end else begin
            gap_next = gap_reg - 4'd1;
          end
        end
        DONE: begin
          state_next = IDLE;
          xpos_next  = '0;
          ypos_next  = '0;
          gap_next   = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_mask[gi] = scan_c && ((xpos_ext + 11'(gi)) < 11'(H_ACTIVE));
    end
  endgenerate

  assign issue_valid = scan_c && ena;
  assign line_end    = scan_c && line_end_c;
  assign frame_done  = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign xpos        = xpos_reg;
  assign ypos        = ypos_reg;

endmodule

// File: tb/tb_array_scan_scheduler.sv
// Directed bench for array_scan_scheduler on a small 10x3 frame, 4 lanes, 2-cycle gap.
module tb_array_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       start;
  logic       pe_ready;
  logic       issue_valid;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic [3:0] lane_mask;
  logic       line_end;
  logic       frame_done;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  array_scan_scheduler #(
    .H_ACTIVE(10),
    .V_ACTIVE(3),
    .LANES(4),
    .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .start(start),
    .pe_ready(pe_ready),
    .issue_valid(issue_valid),
    .xpos(xpos),
    .ypos(ypos),
    .lane_mask(lane_mask),
    .line_end(line_end),
    .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  int xfers;
  int lends;
  int cycles;
  int dones;

  initial begin
    rst = 1'b0; ena = 1'b1; start = 1'b0; pe_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_xpos", 32'(xpos), 32'd0);
    chk("rst_mask", 32'(lane_mask), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);

    rst = 1'b1;
    step();
    chk("idle_no_start", 32'(busy), 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_valid", 32'(issue_valid), 32'd1);
    chk("start_xy", {6'd0, xpos, 6'd0, ypos}, 32'd0);
    chk("start_mask", 32'(lane_mask), 32'hF);
    chk("start_lend", 32'(line_end), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);

    step();
    chk("adv_x4", 32'(xpos), 32'd4);
    // Stall at x=4 for 5 cycles; a start pulse here must be ignored.
    pe_ready = 1'b0;
    start = 1'b1;
    repeat (5) step();
    start = 1'b0;
    chk("stall_x", 32'(xpos), 32'd4);
    chk("stall_valid", 32'(issue_valid), 32'd1);
    chk("stall_y", 32'(ypos), 32'd0);
    pe_ready = 1'b1;
    step();
    chk("x8", 32'(xpos), 32'd8);
    chk("x8_mask", 32'(lane_mask), 32'h3);
    chk("x8_lend", 32'(line_end), 32'd1);

    step();
    chk("gap1_valid", 32'(issue_valid), 32'd0);
    chk("gap1_xy", {6'd0, xpos, 6'd0, ypos}, {6'd0, 10'd0, 6'd0, 10'd1});
    chk("gap1_busy", 32'(busy), 32'd1);
    ena = 1'b0;
    repeat (3) step();
    chk("gapfrz_valid", 32'(issue_valid), 32'd0);
    chk("gapfrz_y", 32'(ypos), 32'd1);
    ena = 1'b1;
    step();
    chk("gap2_valid", 32'(issue_valid), 32'd0);
    step();
    chk("line1_valid", 32'(issue_valid), 32'd1);
    chk("line1_xy", {6'd0, xpos, 6'd0, ypos}, {6'd0, 10'd0, 6'd0, 10'd1});

    ena = 1'b0;
    repeat (3) step();
    chk("scanfrz_valid", 32'(issue_valid), 32'd0);
    chk("scanfrz_x", 32'(xpos), 32'd0);
    chk("scanfrz_mask", 32'(lane_mask), 32'hF);
    ena = 1'b1;
    step();
    chk("line1_x4", 32'(xpos), 32'd4);

    // Asynchronous reset mid-line, away from any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(issue_valid), 32'd0);
    chk("arst_xy", {6'd0, xpos, 6'd0, ypos}, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_mask", 32'(lane_mask), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_done", 32'(frame_done), 32'd0);
    chk("post_rst_idle", 32'(busy), 32'd0);

    ena = 1'b0; start = 1'b1;
    step();
    chk("start_ena0", 32'(busy), 32'd0);
    ena = 1'b1;
    step();
    start = 1'b0;
    chk("restart_xy", {6'd0, xpos, 6'd0, ypos}, 32'd0);
    chk("restart_valid", 32'(issue_valid), 32'd1);

    // Uninterrupted frame: 9 groups, 3 line ends, 3*3 scan + 2*2 gap = 13 cycles.
    xfers = 0; lends = 0; cycles = 0;
    while (!frame_done && cycles < 200) begin
      if (issue_valid) begin
        xfers++;
        if (line_end) lends++;
      end
      step();
      cycles++;
    end
    chk("frame_xfers", 32'(xfers), 32'd9);
    chk("frame_lends", 32'(lends), 32'd3);
    chk("frame_cycles", 32'(cycles), 32'd13);
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("done_valid", 32'(issue_valid), 32'd0);

    ena = 1'b0;
    repeat (2) step();
    chk("done_frozen", 32'(frame_done), 32'd1);
    ena = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("after_done_pulse", 32'(frame_done), 32'd0);
    chk("after_done_busy", 32'(busy), 32'd0);
    chk("after_done_xy", {6'd0, xpos, 6'd0, ypos}, 32'd0);

    dones = 0;
    repeat (5) begin
      step();
      if (frame_done || busy) dones++;
    end
    chk("stays_idle", 32'(dones), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
